// File: rtl/fp32_pkg.sv
// Shared fp32 definitions for the multiplier and the adder: field widths,
// exponent constants, the canonical quiet NaN, FSM states and operand classes.
package fp32_pkg;
    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        NORM,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        DENORM,
        NORMAL,
        INF,
        NAN
    } class_t;
endpackage

// File: rtl/fp32_unpack.sv
// Combinational fp32 field split: sign, effective exponent (denormals use 1),
// mantissa with implicit bit inserted, and operand class.
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0]       x,
    output logic              sign,
    output logic [EXP_W-1:0]  exp_eff,
    output logic [MANT_W:0]   mant,
    output class_t            cls
);
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] f;

    always_comb begin
        e       = x[30:23];
        f       = x[22:0];
        sign    = x[31];
        mant    = {(e != '0), f};
        exp_eff = (e == '0) ? EXP_W'(1) : e;
        if (e == '0)
            cls = (f == '0) ? ZERO : DENORM;
        else if (e == EXP_W'(EXP_MAX))
            cls = (f == '0) ? INF : NAN;
        else
            cls = NORMAL;
    end
endmodule

// File: rtl/fp32_mul_seq.sv
// Iterative truncating fp32 multiplier (shift-add, BITS_PER_CYCLE bits per MULT cycle).
// Define FP32_MUL_FLAGS_EN to add the {overflow, underflow, invalid} flags output.
module fp32_mul_seq
    import fp32_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        busy
`ifdef FP32_MUL_FLAGS_EN
    ,
    output logic [2:0]  flags
`endif
);
    localparam int N = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] LAST = 5'(N - 1);
    localparam logic signed [9:0] EXP_FLOOR = -10'sd126;

    function automatic logic [31:0] pack(input logic s, input logic signed [9:0] e,
                                         input logic [22:0] m);
        if (e >= 10'sd255)
            return {s, 8'hFF, 23'h0};
        else if (e <= 10'sd0)
            return {s, 31'h0};
        else
            return {s, e[7:0], m};
    endfunction

`ifdef FP32_MUL_FLAGS_EN
    // Only reached for finite nonzero products, so any flush is a real underflow.
    function automatic logic [2:0] range_flags(input logic signed [9:0] e);
        return {(e >= 10'sd255), (e <= 10'sd0), 1'b0};
    endfunction
`endif

    logic              ua_sign, ub_sign;
    logic [EXP_W-1:0]  ua_exp, ub_exp;
    logic [MANT_W:0]   ua_mant, ub_mant;
    class_t            ua_cls, ub_cls;

    fp32_unpack u_unpack_a (.x(a), .sign(ua_sign), .exp_eff(ua_exp), .mant(ua_mant), .cls(ua_cls));
    fp32_unpack u_unpack_b (.x(b), .sign(ub_sign), .exp_eff(ub_exp), .mant(ub_mant), .cls(ub_cls));

    state_t             state;
    logic               sign_p;
    logic signed [9:0]  exp_p;
    logic [47:0]        acc;
    logic [47:0]        mcand;
    logic [23:0]        mplier;
    logic [4:0]         cnt;
    logic [47:0]        pp;

    logic        a_big, b_big, a_zero, b_zero;
    logic        special, special_inv;
    logic [31:0] special_y;

    assign pp = mcand * {{(48 - BITS_PER_CYCLE){1'b0}}, mplier[BITS_PER_CYCLE-1:0]};

    always_comb begin
        a_big       = (ua_cls == INF) || (ua_cls == NAN);
        b_big       = (ub_cls == INF) || (ub_cls == NAN);
        a_zero      = (ua_cls == ZERO);
        b_zero      = (ub_cls == ZERO);
        special     = 1'b1;
        special_inv = 1'b0;
        special_y   = {ua_sign ^ ub_sign, 31'h0};
        if ((a_big && b_zero) || (b_big && a_zero)) begin
            special_y   = QNAN;
            special_inv = 1'b1;
        end else if (a_big || b_big) begin
            special_y = {ua_sign ^ ub_sign, 8'hFF, 23'h0};
        end else if (!(a_zero || b_zero)) begin
            special = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            y         <= '0;
            sign_p    <= 1'b0;
            exp_p     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
`ifdef FP32_MUL_FLAGS_EN
            flags     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign_p   <= ua_sign ^ ub_sign;
                    acc      <= '0;
                    mcand    <= {24'h0, ua_mant};
                    mplier   <= ub_mant;
                    cnt      <= '0;
                    exp_p    <= $signed({2'b00, ua_exp}) + $signed({2'b00, ub_exp}) - 10'(BIAS);
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    if (special) begin
                        y         <= special_y;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef FP32_MUL_FLAGS_EN
                        flags     <= {2'b00, special_inv};
`endif
                    end else begin
                        state <= MULT;
                    end
                end
                MULT: begin
                    acc    <= acc + pp;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    cnt    <= cnt + 5'd1;
                    if (cnt == LAST)
                        state <= NORM;
                end
                NORM: begin
                    if (acc[47]) begin
                        y         <= pack(sign_p, exp_p + 10'sd1, acc[46:24]);
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef FP32_MUL_FLAGS_EN
                        flags     <= range_flags(exp_p + 10'sd1);
`endif
                    end else if (acc[46] || (exp_p <= EXP_FLOOR)) begin
                        y         <= pack(sign_p, exp_p, acc[45:23]);
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef FP32_MUL_FLAGS_EN
                        flags     <= range_flags(exp_p);
`endif
                    end else begin
                        // Denormal operand: walk the leading one up one bit per cycle.
                        acc   <= acc << 1;
                        exp_p <= exp_p - 10'sd1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
`ifdef FP32_MUL_FLAGS_EN
                    flags     <= '0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_special_inv;
    assign unused_special_inv = special_inv;
endmodule

// File: tb/tb_fp32_mul_seq.sv
// Self-checking bench for fp32_mul_seq: directed vector table, multi-cycle
// handshake/reset sequences, and randomized operands against a reference model.
module tb_fp32_mul_seq;
    localparam int TMO = 400;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] a, b, y;
`ifdef FP32_MUL_FLAGS_EN
    logic [2:0]  flags;
`endif

    fp32_mul_seq #(.BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .busy(busy)
`ifdef FP32_MUL_FLAGS_EN
        , .flags(flags)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic [2:0]  f;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference: locate the product's leading one directly, then pack with truncation.
    function automatic logic [34:0] ref_mul(input logic [31:0] x, input logic [31:0] z);
        logic s;
        int ex, ez, e, p;
        longint unsigned mx, mz, prod, m;
        logic xz, zz, xb, zb;
        s  = x[31] ^ z[31];
        xz = (x[30:0] == 31'h0);
        zz = (z[30:0] == 31'h0);
        xb = (x[30:23] == 8'hFF);
        zb = (z[30:23] == 8'hFF);
        if ((xb && zz) || (zb && xz)) return {3'b001, 32'h7FC00000};
        if (xb || zb) return {3'b000, s, 8'hFF, 23'h0};
        if (xz || zz) return {3'b000, s, 31'h0};
        mx = {41'h0, (x[30:23] != 0), x[22:0]};
        mz = {41'h0, (z[30:23] != 0), z[22:0]};
        ex = (x[30:23] == 0) ? 1 : int'(x[30:23]);
        ez = (z[30:23] == 0) ? 1 : int'(z[30:23]);
        prod = mx * mz;
        p = 0;
        for (int i = 47; i >= 0; i--)
            if (prod[i] && p == 0) p = i;
        e = ex + ez - 127 + (p - 46);
        m = (p >= 23) ? (prod >> (p - 23)) : (prod << (23 - p));
        if (e >= 255) return {3'b100, s, 8'hFF, 23'h0};
        if (e <= 0) return {3'b010, s, 31'h0};
        return {3'b000, s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        int sel;
        r   = $urandom;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2, 3, 4, 5: return {r[31], 8'($urandom_range(90, 165)), r[22:0]};
            6: return {r[31], 8'h00, r[22:0] | 23'h1};
            7: return r;
            8: return {r[31], 31'h0};
            default: return {r[31], 8'hFF, (r[0] ? r[22:0] : 23'h0)};
        endcase
    endfunction

    task automatic wait_valid(inout int lat, inout logic ir_bad);
        while (!out_valid && lat < TMO) begin
            if (in_ready) ir_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) ir_bad = 1'b1;
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: out_valid still %b after %0d cycles, expected 1", out_valid, lat);
        end
    endtask

    // Called at #1 after an edge with the DUT idle; returns the cycle out_valid rose.
    task automatic do_op(input logic [31:0] xa, input logic [31:0] xb,
                         output logic [31:0] yo, output logic [2:0] fo,
                         output int lat, output logic ir_bad);
        a = xa; b = xb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        ir_bad = 1'b0;
        wait_valid(lat, ir_bad);
        yo = y;
`ifdef FP32_MUL_FLAGS_EN
        fo = flags;
`else
        fo = 3'b000;
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ry, y0;
        logic [2:0]  rf;
        logic [34:0] exp_r;
        logic        irb, stable;
        int          lat;

        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 26};
        vecs[1]  = '{32'h00000000, 32'hC0000000, 32'h80000000, 3'b000, 1};
        vecs[2]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, 1};
        vecs[3]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100, 26};
        vecs[4]  = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b010, 26};
        vecs[5]  = '{32'h00400000, 32'h40000000, 32'h00800000, 3'b000, 27};
        vecs[6]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000, 26};
        vecs[7]  = '{32'hBF800000, 32'h40000000, 32'hC0000000, 3'b000, 26};
        vecs[8]  = '{32'hFF800000, 32'h7F800000, 32'hFF800000, 3'b000, 1};
        vecs[9]  = '{32'h7FC00001, 32'hBF800000, 32'hFF800000, 3'b000, 1};
        vecs[10] = '{32'h00000001, 32'h3F800000, 32'h00000000, 3'b010, 49};
        vecs[11] = '{32'h00000001, 32'h00000001, 32'h00000000, 3'b010, 27};
        vecs[12] = '{32'h80000000, 32'h7FC00000, 32'h7FC00000, 3'b001, 1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_y", y, 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].a, vecs[i].b, ry, rf, lat, irb);
            chk($sformatf("vec%0d_y", i), ry, vecs[i].y);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_in_ready_low", i), 32'(irb), 32'd0);
`ifdef FP32_MUL_FLAGS_EN
            chk($sformatf("vec%0d_flags", i), 32'(rf), 32'(vecs[i].f));
`endif
        end

        // Backpressure: result holds while the consumer stalls, then back-to-back op.
        a = 32'h40400000; b = 32'h3F800000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; irb = 1'b0;
        wait_valid(lat, irb);
        y0 = y;
        chk("bp_y", y0, 32'h40400000);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (y !== y0 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        chk("bp_hold_stable", 32'(stable), 32'd1);
        out_ready = 1'b1;
        a = 32'h3FC00000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_accepted", 32'(in_ready), 32'd0);
        lat = 1; irb = 1'b0;
        wait_valid(lat, irb);
        chk("bp_second_y", y, 32'h40400000);
        chk("bp_second_latency", 32'(lat), 32'd26);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of MULT discards the partial product.
        a = 32'h3FC00000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_y", y, 32'h0);
        chk("midrst_busy", 32'(busy), 32'd0);
        do_op(32'h3FC00000, 32'h40000000, ry, rf, lat, irb);
        chk("midrst_after_y", ry, 32'h40400000);
        chk("midrst_after_latency", 32'(lat), 32'd26);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra, rb;
            ra = rand_op();
            rb = rand_op();
            exp_r = ref_mul(ra, rb);
            do_op(ra, rb, ry, rf, lat, irb);
            chk($sformatf("rand%0d_y(%h*%h)", i, ra, rb), ry, exp_r[31:0]);
`ifdef FP32_MUL_FLAGS_EN
            chk($sformatf("rand%0d_flags(%h*%h)", i, ra, rb), 32'(rf), 32'(exp_r[34:32]));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
